// File: rtl/frame_sync_detector.sv
// frame_sync_detector
//
// Byte-wide frame delineator for the descrambled byte stream. It hunts for
// SYNC_BYTE repeating every FRAME_LEN bytes and confirms the alignment over
// LOCK_COUNT frames. It then forwards aligned bytes with a start-of-frame flag.
// A flywheel state rides through isolated sync corruption. Lock is dropped
// after LOSS_COUNT consecutive sync misses.
//
// Parameters:
//   SYNC_BYTE  - sync pattern at frame position 0
//   FRAME_LEN  - bytes per frame including sync (>= 2)
//   LOCK_COUNT - consecutive correctly spaced syncs needed to lock (>= 1)
//   LOSS_COUNT - consecutive sync misses while locked that drop lock (>= 1)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   in_valid    in   din carries a byte this cycle
//   din         in   descrambled byte
//   out_valid   out  dout is an aligned frame byte
//   dout        out  forwarded byte
//   sof         out  dout is frame position 0 (qualified by out_valid)
//   locked      out  state is LOCKED or FLYWHEEL
//   state       out  HUNT=0, CONFIRM=1, LOCKED=2, FLYWHEEL=3
//   lock_lost   out  one-cycle pulse when lock is dropped back to HUNT
//   frame_count out  emitted frames (wraps)
//   miss_count  out  sync misses while locked (saturates)
//
// Build option: define FRAME_SYNC_STATS_EN to include the frame_count and
// miss_count counters. Without it, both outputs are tied to zero.

module frame_sync_detector #(
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         FRAME_LEN  = 16,
  parameter int         LOCK_COUNT = 3,
  parameter int         LOSS_COUNT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  din,
  output logic        out_valid,
  output logic [7:0]  dout,
  output logic        sof,
  output logic        locked,
  output logic [1:0]  state,
  output logic        lock_lost,
  output logic [15:0] frame_count,
  output logic [15:0] miss_count
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    CONFIRM  = 2'd1,
    LOCKED   = 2'd2,
    FLYWHEEL = 2'd3
  } state_t;

  state_t         st, st_nxt;
  logic [PW-1:0]  pos, pos_nxt, pos_inc;
  logic [GW-1:0]  good, good_nxt, good_inc;
  logic [MW-1:0]  miss, miss_nxt, miss_inc;
  logic           sync_chk, match;
  logic           emit, sof_nxt, lost_nxt, miss_evt;

  assign pos_inc  = (pos == PW'(FRAME_LEN - 1)) ? '0 : pos + 1'b1;
  assign good_inc = good + 1'b1;
  assign miss_inc = miss + 1'b1;
  assign sync_chk = (pos == '0);
  assign match    = (din == SYNC_BYTE);

  // Next-state and per-byte decisions; nothing moves without an accepted byte.
  always_comb begin
    st_nxt   = st;
    pos_nxt  = pos;
    good_nxt = good;
    miss_nxt = miss;
    lost_nxt = 1'b0;
    miss_evt = 1'b0;
    if (in_valid) begin
      pos_nxt = pos_inc;
      case (st)
        HUNT: begin
          // Every byte is a candidate; pos stays parked at 0 until a match.
          pos_nxt = '0;
          if (match) begin
            pos_nxt  = PW'(1);
            good_nxt = GW'(1);
            st_nxt   = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (sync_chk) begin
            if (match) begin
              good_nxt = good_inc;
              if (good_inc == GW'(LOCK_COUNT)) st_nxt = LOCKED;
            end else begin
              // The failing byte is consumed here, not re-hunted.
              st_nxt   = HUNT;
              pos_nxt  = '0;
              good_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (sync_chk && !match) begin
            miss_evt = 1'b1;
            if (LOSS_COUNT == 1) begin
              st_nxt   = HUNT;
              pos_nxt  = '0;
              good_nxt = '0;
              miss_nxt = '0;
              lost_nxt = 1'b1;
            end else begin
              st_nxt   = FLYWHEEL;
              miss_nxt = MW'(1);
            end
          end
        end
        FLYWHEEL: begin
          if (sync_chk) begin
            if (match) begin
              miss_nxt = '0;
              st_nxt   = LOCKED;
            end else begin
              miss_evt = 1'b1;
              miss_nxt = miss_inc;
              if (miss_inc == MW'(LOSS_COUNT)) begin
                st_nxt   = HUNT;
                pos_nxt  = '0;
                good_nxt = '0;
                miss_nxt = '0;
                lost_nxt = 1'b1;
              end
            end
          end
        end
        default: st_nxt = HUNT;
      endcase
    end
  end

  // A byte is emitted when its own update leaves us in a locked state, so the
  // lock-completing sync is emitted and the lock-dropping byte is not.
  assign emit    = in_valid && ((st_nxt == LOCKED) || (st_nxt == FLYWHEEL));
  assign sof_nxt = (st == HUNT) || sync_chk;

  // Control state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st   <= HUNT;
      pos  <= '0;
      good <= '0;
      miss <= '0;
    end else begin
      st   <= st_nxt;
      pos  <= pos_nxt;
      good <= good_nxt;
      miss <= miss_nxt;
    end
  end

  // Registered outputs, one cycle behind the accepted byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sof       <= 1'b0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      locked <= (st_nxt == LOCKED) || (st_nxt == FLYWHEEL);
      if (in_valid) begin
        out_valid <= emit;
        dout      <= din;
        sof       <= emit && sof_nxt;
        lock_lost <= lost_nxt;
      end else begin
        out_valid <= 1'b0;
        lock_lost <= 1'b0;
      end
    end
  end

  assign state = st;

`ifdef FRAME_SYNC_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] frame_cnt, miss_cnt;

  // Statistics counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      if (emit && sof_nxt) frame_cnt <= frame_cnt + 16'd1;
      if (miss_evt)        miss_cnt  <= sat_inc16(miss_cnt);
    end
  end

  assign frame_count = frame_cnt;
  assign miss_count  = miss_cnt;
`else
  logic unused_miss_evt;
  assign unused_miss_evt = miss_evt;
  assign frame_count     = '0;
  assign miss_count      = '0;
`endif

endmodule
